regs_wb: RTL and testbench

- Writeback controller that drives the write port (WB, Rd, reg_s) of the DLX register file.
- Merges two result sources:
  - single-cycle ALU results, which always win;
  - variable-latency load responses from the memory side, buffered in a small FIFO behind a valid/ready handshake.
- Keeps a pending-load scoreboard so decode can stall on RAW/WAW hazards against outstanding loads.

---
 rtl/regs_wb.sv | 105 ++++++++++
 tb/tb_regs_wb.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regs_wb.sv
// regs_wb: DLX writeback merging ALU results (priority) with FIFO-buffered load responses, plus pending-load scoreboard.
// Write port registered: 1 cycle from ALU, >=2 cycles from load accept; mem_ready drops only while the FIFO is full.
module regs_wb #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        WB,
  output logic [4:0]  Rd,
  output logic [31:0] reg_s,
  output logic [31:0] pend,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t          fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  ent_t          head;
  logic          accept;
  logic          push;
  logic          alu_win;
  logic          pop;
  logic          err_hit;
  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;

  // Full blocks acceptance even when a pop frees a slot this cycle.
  assign mem_ready = (count != FULL) && rst_n;
  assign accept    = mem_valid && mem_ready;
  assign push      = accept && (mem_rd != 5'd0);
  assign alu_win   = alu_valid && (alu_rd != 5'd0);
  assign pop       = !alu_win && (count != '0);
  assign head      = fifo_q[rd_ptr];

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid) set_mask[iss_rd] = 1'b1;
    if (pop)       clr_mask[head.rd] = 1'b1;
    set_mask[0] = 1'b0;
  end

  assign err_hit = (iss_valid && (iss_rd != 5'd0) && pend[iss_rd])
                || (accept && (mem_rd != 5'd0) && !pend[mem_rd])
                || (alu_win && pend[alu_rd]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      WB     <= 1'b0;
      Rd     <= '0;
      reg_s  <= '0;
      pend   <= '0;
      err    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= '{rd: mem_rd, data: mem_data};
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (alu_win) begin
        WB    <= 1'b1;
        Rd    <= alu_rd;
        reg_s <= alu_data;
      end else if (pop) begin
        WB    <= 1'b1;
        Rd    <= head.rd;
        reg_s <= head.data;
      end else begin
        WB    <= 1'b0;
      end

      // Set beats clear so a re-issue to the register being retired stays pending.
      pend <= ((pend & ~clr_mask) | set_mask) & ~32'd1;
      if (err_hit) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regs_wb.sv
// Directed bench for regs_wb: expected register-file writes are queued with their due cycle and
// checked by a negedge monitor; control/status outputs are checked inline.
module tb_regs_wb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        WB;
  logic [4:0]  Rd;
  logic [31:0] reg_s;
  logic [31:0] pend;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  regs_wb #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .WB(WB), .Rd(Rd), .reg_s(reg_s), .pend(pend), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data, input int due);
    sb.push_back('{rd, data, due});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every write must match the head entry exactly on its due cycle.
  always @(negedge clk) begin
    if (WB) begin
      if (sb.size() == 0) begin
        chk("unexpected_wb", {31'd0, WB}, 32'd0);
      end else begin
        chk("wb_cycle", cyc, sb[0].due);
        chk("wb_rd", {27'd0, Rd}, {27'd0, sb[0].rd});
        chk("wb_data", reg_s, sb[0].data);
        sb.delete(0);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      chk("missing_wb", {31'd0, WB}, 32'd1);
      sb.delete(0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] nxt;
    rst_n = 1'b0; alu_valid = 0; alu_rd = 0; alu_data = 0;
    iss_valid = 0; iss_rd = 0; mem_valid = 0; mem_rd = 0; mem_data = 0;

    // Reset then idle
    tick(); tick();
    chk("rst_wb", WB, 0);
    chk("rst_pend", pend, 0);
    chk("rst_err", err, 0);
    chk("rst_ready_low", mem_ready, 0);
    rst_n = 1'b1;
    #1 chk("idle_ready", mem_ready, 1);

    // ALU path, then alu_rd==0 ignored with Rd/reg_s holding
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    expect_wb(5, 32'hDEADBEEF, cyc + 1);
    tick();
    chk("alu_wb", WB, 1);
    chk("alu_rd", Rd, 5);
    chk("alu_data", reg_s, 32'hDEADBEEF);
    alu_rd = 0; alu_data = 32'h11111111;
    tick();
    alu_valid = 0;
    chk("alu_r0_wb", WB, 0);
    chk("alu_r0_hold_rd", Rd, 5);
    chk("alu_r0_hold_data", reg_s, 32'hDEADBEEF);

    // Load path
    iss_valid = 1; iss_rd = 7;
    tick();
    iss_valid = 0;
    chk("load_pend7", pend, 32'h80);
    tick();
    mem_valid = 1; mem_rd = 7; mem_data = 32'h12345678;
    expect_wb(7, 32'h12345678, cyc + 2);
    tick();
    mem_valid = 0;
    chk("load_no_bypass", WB, 0);
    chk("load_pend_held", pend, 32'h80);
    tick();
    chk("load_wb", WB, 1);
    chk("load_pend_clear", pend, 0);
    chk("load_err", err, 0);

    // Priority and backpressure
    for (int i = 1; i <= 5; i++) begin
      iss_valid = 1; iss_rd = 5'(i);
      tick();
    end
    iss_valid = 0;
    chk("pend_r1_r5", pend, 32'h3E);
    alu_valid = 1; alu_rd = 9;
    nxt = 5'd1;
    for (int k = 0; k < 6; k++) begin
      alu_data = 32'h9000_0000 + k;
      expect_wb(9, alu_data, cyc + 1);
      mem_valid = 1; mem_rd = nxt; mem_data = 32'hA000_0000 + {27'd0, nxt};
      #1 chk(k >= 4 ? "ready_full" : "ready_fill", mem_ready, (k >= 4) ? 32'd0 : 32'd1);
      tick();
      if (k < 4) nxt = nxt + 5'd1;
    end
    alu_valid = 0;
    expect_wb(1, 32'hA000_0001, cyc + 1);
    #1 chk("ready_full_while_pop", mem_ready, 0);
    tick();
    expect_wb(2, 32'hA000_0002, cyc + 1);
    chk("ready_after_pop", mem_ready, 1);
    tick();
    mem_valid = 0;
    // r3 pops while r3 is re-issued
    iss_valid = 1; iss_rd = 3;
    expect_wb(3, 32'hA000_0003, cyc + 1);
    tick();
    iss_valid = 0;
    chk("setclr_pend", pend, 32'h38);
    chk("setclr_err", err, 1);
    expect_wb(4, 32'hA000_0004, cyc + 1);
    tick();
    expect_wb(5, 32'hA000_0005, cyc + 1);
    tick();
    chk("drain_pend", pend, 32'h08);
    tick();
    chk("drain_idle", WB, 0);

    // Error sticky, write still performed
    rst_n = 0; tick(); rst_n = 1;
    chk("rst2_err", err, 0);
    mem_valid = 1; mem_rd = 12; mem_data = 32'hCAFEF00D;
    expect_wb(12, 32'hCAFEF00D, cyc + 2);
    tick();
    mem_valid = 0;
    chk("stray_err", err, 1);
    tick(); tick(); tick();
    chk("err_sticky", err, 1);

    // Reset with three buffered responses discards them
    alu_valid = 1; alu_rd = 10;
    for (int k = 0; k < 3; k++) begin
      alu_data = 32'hB000_0000 + k;
      expect_wb(10, alu_data, cyc + 1);
      mem_valid = 1; mem_rd = 5'(20 + k); mem_data = 32'hC000_0000 + k;
      tick();
    end
    chk("pre_reset_err", err, 1);
    rst_n = 0; alu_valid = 0; mem_valid = 0;
    tick(); tick();
    rst_n = 1;
    chk("rst3_wb", WB, 0);
    chk("rst3_err", err, 0);
    chk("rst3_pend", pend, 0);
    #1 chk("rst3_ready", mem_ready, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_reset_no_wb", WB, 0);
    end
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
